// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALU op codes, M-extension op codes, sequencer states and decode constants.
// rev 1.0
`default_nettype none

package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_BEQ  = 4'b1000,
    ALU_SLT  = 4'b1001,
    ALU_SLTU = 4'b1010,
    ALU_BNE  = 4'b1011,
    ALU_BLT  = 4'b1100,
    ALU_BGE  = 4'b1101,
    ALU_BLTU = 4'b1110,
    ALU_BGEU = 4'b1111
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_REG    = 2'b10;
  localparam logic [1:0] ALUOP_JUMP   = 2'b11;

  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic op_signed_a(input muldiv_op_e op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic op_signed_b(input muldiv_op_e op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_controller_m_muldiv_iter.sv
// muldiv_iter: unsigned shift-add multiply / restoring divide, ITER_BITS per step on a {hi,lo} register.
// rev 1.0 -- ALU_CTRL_FAST_MUL_EN replaces the iterative multiply step with a full-width product.
`default_nettype none

module muldiv_iter #(
  parameter int XLEN      = 32,
  parameter int ITER_BITS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                step,
  input  logic                div_mode,
  input  logic [XLEN-1:0]     lo_in,
  input  logic [XLEN-1:0]     mcand_in,
  output logic [2*XLEN-1:0]   prod
);

  logic [XLEN-1:0] hi, lo, mcand;
  logic [XLEN-1:0] mul_hi, mul_lo, div_hi, div_lo;

`ifdef ALU_CTRL_FAST_MUL_EN
  logic [2*XLEN-1:0] full_prod;

  assign full_prod = {{XLEN{1'b0}}, lo} * {{XLEN{1'b0}}, mcand};
  assign mul_hi    = full_prod[2*XLEN-1:XLEN];
  assign mul_lo    = full_prod[XLEN-1:0];
`else
  logic [XLEN+ITER_BITS-1:0] acc;

  // lo holds the unconsumed multiplier bits; the product fills in from the top
  always_comb begin
    acc = {{ITER_BITS{1'b0}}, hi};
    for (int k = 0; k < ITER_BITS; k++) begin
      if (lo[k]) acc = acc + ({{ITER_BITS{1'b0}}, mcand} << k);
    end
    {mul_hi, mul_lo} = {acc, lo[XLEN-1:ITER_BITS]};
  end
`endif

  logic [XLEN:0]   part_rem;
  logic [XLEN-1:0] part_quo;

  // hi is the partial remainder, lo shifts the dividend out and the quotient in
  always_comb begin
    part_rem = {1'b0, hi};
    part_quo = lo;
    for (int k = 0; k < ITER_BITS; k++) begin
      part_rem = {part_rem[XLEN-1:0], part_quo[XLEN-1]};
      part_quo = {part_quo[XLEN-2:0], 1'b0};
      if (part_rem >= {1'b0, mcand}) begin
        part_rem    = part_rem - {1'b0, mcand};
        part_quo[0] = 1'b1;
      end
    end
    div_hi = part_rem[XLEN-1:0];
    div_lo = part_quo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
    end else if (load) begin
      hi    <= '0;
      lo    <= lo_in;
      mcand <= mcand_in;
    end else if (step) begin
      if (div_mode) begin
        hi <= div_hi;
        lo <= div_lo;
      end else begin
        hi <= mul_hi;
        lo <= mul_lo;
      end
    end
  end

  assign prod = {hi, lo};

endmodule

`default_nettype wire

// File: rtl/alu_controller_m.sv
// alu_controller_m: ALU decode plus valid/ready RV32M/RV64M multiply-divide sequencer.
// rev 1.0 -- define ALU_CTRL_FAST_MUL_EN for a single-cycle multiply (MUL* latency 3).
`default_nettype none

module alu_controller_m
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ITER_BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      ALUOp,
  input  logic            IsRType,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  output logic [3:0]      Operation,
  output logic            IsMulDiv,
  input  logic            ReqValid,
  output logic            ReqReady,
  input  logic [XLEN-1:0] OpA,
  input  logic [XLEN-1:0] OpB,
  output logic            RspValid,
  input  logic            RspReady,
  output logic [XLEN-1:0] Result,
  output logic            Busy
);

  localparam int N     = XLEN / ITER_BITS;
  localparam int CNT_W = $clog2(N + 1);

  alu_op_e op_dec;

  assign IsMulDiv = (ALUOp == ALUOP_REG) && IsRType && (Funct7 == FUNCT7_MULDIV);

  always_comb begin
    op_dec = ALU_ADD;
    case (ALUOp)
      ALUOP_BRANCH: begin
        case (Funct3)
          3'b000:  op_dec = ALU_BEQ;
          3'b001:  op_dec = ALU_BNE;
          3'b100:  op_dec = ALU_BLT;
          3'b101:  op_dec = ALU_BGE;
          3'b110:  op_dec = ALU_BLTU;
          3'b111:  op_dec = ALU_BGEU;
          default: op_dec = ALU_ADD;
        endcase
      end
      ALUOP_REG: begin
        if (!IsMulDiv) begin
          case (Funct3)
            3'b000:  op_dec = (IsRType && Funct7 == FUNCT7_ALT) ? ALU_SUB : ALU_ADD;
            3'b001:  op_dec = ALU_SLL;
            3'b010:  op_dec = ALU_SLT;
            3'b011:  op_dec = ALU_SLTU;
            3'b100:  op_dec = ALU_XOR;
            3'b101:  op_dec = (Funct7 == FUNCT7_ALT) ? ALU_SRA : ALU_SRL;
            3'b110:  op_dec = ALU_OR;
            default: op_dec = ALU_AND;
          endcase
        end
      end
      default: op_dec = ALU_ADD;
    endcase
  end

  assign Operation = op_dec;

  state_e          state, state_nxt;
  logic [CNT_W-1:0] count;
  muldiv_op_e      op_q;
  logic            neg_a, neg_b, b_zero;
  logic [XLEN-1:0] result;
  logic            accept;

  assign ReqReady = (state == ST_IDLE);
  assign Busy     = (state != ST_IDLE);
  assign RspValid = (state == ST_DONE);
  assign Result   = result;
  assign accept   = ReqValid && ReqReady && IsMulDiv;

  muldiv_op_e      op_in;
  logic            sign_a_in, sign_b_in;
  logic [XLEN-1:0] mag_a, mag_b;

  assign op_in     = muldiv_op_e'(Funct3);
  assign sign_a_in = op_signed_a(op_in) && OpA[XLEN-1];
  assign sign_b_in = op_signed_b(op_in) && OpB[XLEN-1];
  assign mag_a     = sign_a_in ? -OpA : OpA;
  assign mag_b     = sign_b_in ? -OpB : OpB;

  logic [2*XLEN-1:0] prod;

  // divide keeps the dividend in lo and the divisor as mcand; multiply the reverse
  muldiv_iter #(
    .XLEN      (XLEN),
    .ITER_BITS (ITER_BITS)
  ) u_muldiv_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .step     ((state == ST_MUL) || (state == ST_DIV)),
    .div_mode (state == ST_DIV),
    .lo_in    (Funct3[2] ? mag_a : mag_b),
    .mcand_in (Funct3[2] ? mag_b : mag_a),
    .prod     (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = Funct3[2] ? ST_DIV : ST_MUL;
`ifdef ALU_CTRL_FAST_MUL_EN
      ST_MUL:  state_nxt = ST_FIX;
`else
      ST_MUL:  if (count == CNT_W'(1)) state_nxt = ST_FIX;
`endif
      ST_DIV:  if (count == CNT_W'(1)) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
      ST_DONE: if (RspReady) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   quo, rem, fix_val;

  assign prod_signed = (neg_a ^ neg_b) ? -prod : prod;
  assign quo         = prod[XLEN-1:0];
  assign rem         = prod[2*XLEN-1:XLEN];

  // a zero divisor forces all-ones; the remainder sign follows the dividend
  always_comb begin
    fix_val = '0;
    case (op_q)
      MD_MUL:                        fix_val = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  fix_val = prod_signed[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               fix_val = b_zero ? '1 : ((neg_a ^ neg_b) ? -quo : quo);
      default:                       fix_val = neg_a ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      op_q   <= MD_MUL;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      b_zero <= 1'b0;
      result <= '0;
    end else begin
      if (accept) begin
        count  <= CNT_W'(N);
        op_q   <= op_in;
        neg_a  <= sign_a_in;
        neg_b  <= sign_b_in;
        b_zero <= (OpB == '0);
      end else if ((state == ST_MUL) || (state == ST_DIV)) begin
        count <= count - CNT_W'(1);
      end
      if (state == ST_FIX) result <= fix_val;
    end
  end

endmodule

`default_nettype wire
